// File: rtl/mem_seq_pkg.sv
// Shared constants for the scratch-memory sequencer: FSM encoding,
// default bus widths and request-type codes.
package mem_seq_pkg;

  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_seq_iobuf.sv
// Tri-state driver for the controller's side of the memory data bus.
// The bus is driven only while oe_i is high; the sampled bus is always visible.
module mem_seq_iobuf #(
  parameter int DW = 8
) (
  input  logic          oe_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  inout  wire  [DW-1:0] bus_io
);

  assign bus_io  = oe_i ? wdata_i : {DW{1'bz}};
  assign rdata_o = bus_io;

endmodule

// File: rtl/mem_seq_ctrl.sv
// One-at-a-time read/write sequencer in front of a single-port synchronous memory.
// Define MEM_SEQ_CTRL_WRACK_EN to return a response (write-data echo) for writes too.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  inout  wire  [DWIDTH-1:0] mem_data_io,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // req_ready is high only in IDLE; rsp_valid holds with stable data until accepted.
  state_e            state_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              mem_wr_q;
  logic              mem_rd_q;
  logic              drive_q;
  logic              rsp_valid_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic [DWIDTH-1:0] bus_sample;

  mem_seq_iobuf #(.DW(DWIDTH)) u_iobuf (
    .oe_i    (drive_q),
    .wdata_i (wdata_q),
    .rdata_o (bus_sample),
    .bus_io  (mem_data_io)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            if (req_wr_i == REQ_WR) begin
              state_q  <= ST_WRITE;
              mem_wr_q <= 1'b1;
              drive_q  <= 1'b1;
            end else begin
              state_q <= ST_RD_ADDR;
            end
          end
        end
        ST_WRITE: begin
          mem_wr_q <= 1'b0;
          drive_q  <= 1'b0;
`ifdef MEM_SEQ_CTRL_WRACK_EN
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= wdata_q;
          state_q     <= ST_RESP;
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_RD_ADDR: begin
          // Memory registers its word at this edge; open its output next cycle.
          mem_rd_q <= 1'b1;
          state_q  <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          mem_rd_q    <= 1'b0;
          rsp_rdata_q <= bus_sample;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so ready is low for the whole time reset is held.
  assign req_ready_o = rst_n && (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_addr_o  = addr_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_rd_o    = mem_rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with a behavioural single-port synchronous memory.
// Honours MEM_SEQ_CTRL_WRACK_EN when the design is built with it.
module tb_mem_seq_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic          mem_rd;
  wire  [DW-1:0] mem_data;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  mem_seq_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .mem_addr_o  (mem_addr),
    .mem_wr_o    (mem_wr),
    .mem_rd_o    (mem_rd),
    .mem_data_io (mem_data),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word registered every edge, driven onto the bus while rd is high
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] mem_rword;
  always @(posedge clk) begin
    if (mem_wr) mem_arr[mem_addr] <= mem_data;
    mem_rword <= mem_arr[mem_addr];
  end
  assign mem_data = mem_rd ? mem_rword : {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller must never drive the bus while the memory is reading onto it
  always @(negedge clk) begin
    if (rst_n && mem_rd && dut.drive_q)
      chk("bus_contention", 32'd1, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr = 1'b1; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_ready();
    tick();
    req_valid = 1'b0;
    chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("wr_addr", {27'd0, mem_addr}, {27'd0, a});
    chk("wr_bus", {24'd0, mem_data}, {24'd0, d});
    tick();
    chk("wr_done_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("wr_committed", {24'd0, mem_arr[a]}, {24'd0, d});
`ifdef MEM_SEQ_CTRL_WRACK_EN
    chk("wrack_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wrack_data", {24'd0, rsp_rdata}, {24'd0, d});
    tick();
`endif
    chk("wr_rsp_idle", {31'd0, rsp_valid}, 32'd0);
  endtask

  // Issues a read and returns just after the edge that raises rsp_valid
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr = 1'b0; req_addr = a; req_valid = 1'b1;
    wait_ready();
    tick();
    req_valid = 1'b0;
    chk("rd_addr_state", {29'd0, dbg_state}, 32'd2);
    chk("rd_addr", {27'd0, mem_addr}, {27'd0, a});
    chk("rd_addr_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rd_addr_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rd_data_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rd_data_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_data", {24'd0, rsp_rdata}, {24'd0, d});
    chk("rd_rsp_ready_low", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic sample_rsp();
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else chk("stream_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    int n;
    int cyc;
    logic acc;
    logic [DW-1:0] last_wr;

    rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; last_wr = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_bus_z", {31'd0, mem_data === 8'hzz}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Basic write/read with single-cycle response pulse
    do_write(5'd3, 8'hA5);
    do_read(5'd3, 8'hA5);
    tick();
    chk("rsp_pulse_drop", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_back_idle", {31'd0, req_ready}, 32'd1);

    // Address extremes
    do_write(5'd0, 8'h11);
    do_write(5'd31, 8'hEE);
    do_read(5'd0, 8'h11);
    tick();
    do_read(5'd31, 8'hEE);
    tick();
    chk("extreme_drop", {31'd0, rsp_valid}, 32'd0);

    // Response backpressure
    rsp_ready = 1'b0;
    do_read(5'd3, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {24'd0, rsp_rdata}, 32'hA5);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle", {31'd0, req_ready}, 32'd1);

    // Alternating write/read stream, req_valid held high
    n = 0; cyc = 0;
    req_valid = 1'b1;
    while (n < 16 && cyc < 200) begin
      req_wr    = (n % 2 == 0);
      req_addr  = 5'(8 + n / 2);
      req_wdata = 8'(8'h30 + n * 7);
      acc = req_ready;
      tick();
      cyc++;
      if (acc) begin
        if (req_wr) begin
          last_wr = req_wdata;
`ifdef MEM_SEQ_CTRL_WRACK_EN
          exp_q.push_back(req_wdata);
`endif
        end else begin
          exp_q.push_back(last_wr);
        end
        n++;
      end
      sample_rsp();
    end
    req_valid = 1'b0;
    chk("stream_accepted", n, 32'd16);
    for (int i = 0; i < 6; i++) begin
      tick();
      sample_rsp();
    end
    chk("stream_drained", exp_q.size(), 32'd0);

    // Reset during RD_DATA
    req_wr = 1'b0; req_addr = 5'd3; req_valid = 1'b1;
    wait_ready();
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_rd_data_state", {29'd0, dbg_state}, 32'd3);
    chk("mid_rd_mem_rd", {31'd0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_bus_z", {31'd0, mem_data === 8'hzz}, 32'd1);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("mid_release_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Write acknowledge behaviour (checked inside do_write) and recovery read
    do_write(5'd7, 8'h5A);
    do_read(5'd7, 8'h5A);
    tick();
    chk("final_drop", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
